// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmit path: FSM states and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // 12 MHz board clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART shifter; count-based full/empty flags.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  // A full FIFO refuses the push even when a pop happens on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake, FIFO, LSB-first serializer
// with back-to-back frames and no idle gap between queued bytes.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       tx,
  output logic       is_transmitting,
  output logic       tx_done,
  output logic       fifo_empty
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   pop;
  logic [DATA_BITS-1:0]   fifo_data;
  logic                   fifo_full;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (DATA_BITS)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (tx_valid),
    .data_i (tx_byte),
    .pop_i  (pop),
    .data_o (fifo_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign tx_ready        = !fifo_full;
  assign tx              = tx_q;
  assign tx_done         = done_q;
  assign is_transmitting = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // Next bit is driven straight from shift_q[1] so tx stays registered.
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          done_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered against a frame-timing reference model.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_ready, tx, is_transmitting, tx_done, fifo_empty;

  int tests = 0;
  int fails = 0;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tx_valid       (tx_valid),
    .tx_byte        (tx_byte),
    .tx_ready       (tx_ready),
    .tx             (tx),
    .is_transmitting(is_transmitting),
    .tx_done        (tx_done),
    .fifo_empty     (fifo_empty)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus the start edge of the frame on the line.
  logic [7:0] mq[$];
  int         cyc = 0;
  bit         have_frame = 1'b0;
  int         f_start = 0;
  int         f_end = 0;
  logic [7:0] f_byte = 8'h00;
  bit         exp_done = 1'b0;
  int         acc_cnt = 0;
  int         done_cnt = 0;

  always @(posedge clk or posedge rst) begin
    bit acc;
    bit popm;
    if (rst) begin
      mq.delete();
      have_frame = 1'b0;
      exp_done   = 1'b0;
    end else begin
      cyc++;
      acc      = tx_valid && (mq.size() < DEPTH);
      exp_done = have_frame && (cyc == f_end);
      if (have_frame && cyc >= f_end) have_frame = 1'b0;
      popm = (mq.size() > 0) && !have_frame;
      if (popm) begin
        f_byte     = mq.pop_front();
        f_start    = cyc;
        f_end      = cyc + FRAME;
        have_frame = 1'b1;
      end
      if (acc) begin
        mq.push_back(tx_byte);
        acc_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && tx_done) done_cnt++;
  end

  // {tx, tx_ready, fifo_empty, is_transmitting, tx_done}
  function automatic logic [4:0] model_exp();
    logic t;
    int   k;
    t = 1'b1;
    if (have_frame) begin
      k = (cyc - f_start) / CPB;
      if (k == 0)      t = 1'b0;
      else if (k <= 8) t = f_byte[k-1];
    end
    return {t, (mq.size() < DEPTH), (mq.size() == 0), have_frame, exp_done};
  endfunction

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs = {tx, tx_ready, fifo_empty, is_transmitting, tx_done};
    tests++;
    if (obs !== 5'b11100) begin
      fails++;
      $display("FAIL reset_held: got %b expected %b", obs, 5'b11100);
    end
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      obs = {tx, tx_ready, fifo_empty, is_transmitting, tx_done};
      tests++;
      if (obs !== 5'b11100) begin
        fails++;
        $display("FAIL reset_idle: got %b expected %b at %0t", obs, 5'b11100, $time);
      end
    end
  endtask

  task automatic test_single();
    logic [9:0] fr;
    int         d0;
    fr = {1'b1, 8'h41, 1'b0};
    d0 = done_cnt;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_byte  = 8'h41;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    tests++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL single_latency: tx got %b expected 1 before edge N+1", tx);
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      tests++;
      if ({tx, is_transmitting, tx_done} !== {fr[k/CPB], 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL single_bit%0d: got %b expected %b", k,
                 {tx, is_transmitting, tx_done}, {fr[k/CPB], 1'b1, 1'b0});
      end
    end
    @(negedge clk);
    tests++;
    if ({tx, is_transmitting, tx_done} !== 3'b101) begin
      fails++;
      $display("FAIL single_end: got %b expected 101", {tx, is_transmitting, tx_done});
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5];
    logic [4:0] obs, ev;
    int         busy, d0;
    bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'h00; bytes[3] = 8'hFF; bytes[4] = 8'h0F;
    busy = 0;
    d0   = done_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (is_transmitting) busy++;
      tests++;
      if (tx_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready%0d: got %b expected 1", i, tx_ready);
      end
      tx_valid = 1'b1;
      tx_byte  = bytes[i];
    end
    @(negedge clk);
    if (is_transmitting) busy++;
    tests++;
    if (tx_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_full: tx_ready got %b expected 0", tx_ready);
    end
    tx_valid = 1'b0;
    repeat (5 * FRAME + 10) begin
      @(negedge clk);
      if (is_transmitting) busy++;
      obs = {tx, tx_ready, fifo_empty, is_transmitting, tx_done};
      ev  = model_exp();
      tests++;
      if (obs !== ev) begin
        fails++;
        $display("FAIL b2b_line: got %b expected %b at %0t", obs, ev, $time);
      end
    end
    tests++;
    if (busy !== 5 * FRAME) begin
      fails++;
      $display("FAIL b2b_contiguous: busy cycles got %0d expected %0d", busy, 5 * FRAME);
    end
    tests++;
    if (done_cnt - d0 !== 5) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d expected 5", done_cnt - d0);
    end
  endtask

  task automatic test_random();
    logic [4:0] obs, ev;
    int         a0, d0, sent, guard;
    a0 = acc_cnt;
    d0 = done_cnt;
    sent  = 0;
    guard = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_byte  = 8'($urandom);
    while ((acc_cnt - a0) < 64 && guard < 20000) begin
      @(negedge clk);
      guard++;
      obs = {tx, tx_ready, fifo_empty, is_transmitting, tx_done};
      ev  = model_exp();
      tests++;
      if (obs !== ev) begin
        fails++;
        $display("FAIL random_line: got %b expected %b at %0t", obs, ev, $time);
      end
      if (acc_cnt - a0 != sent) begin
        sent = acc_cnt - a0;
        if (sent < 64) begin
          tx_valid = ($urandom_range(0, 3) != 0);
          tx_byte  = 8'($urandom);
        end else begin
          tx_valid = 1'b0;
        end
      end else if (!tx_valid) begin
        tx_valid = ($urandom_range(0, 1) == 1);
        tx_byte  = 8'($urandom);
      end
    end
    tx_valid = 1'b0;
    while ((have_frame || mq.size() > 0) && guard < 20000) begin
      @(negedge clk);
      guard++;
      obs = {tx, tx_ready, fifo_empty, is_transmitting, tx_done};
      ev  = model_exp();
      tests++;
      if (obs !== ev) begin
        fails++;
        $display("FAIL random_drain: got %b expected %b at %0t", obs, ev, $time);
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (acc_cnt - a0 !== 64) begin
      fails++;
      $display("FAIL random_accepted: got %0d expected 64", acc_cnt - a0);
    end
    tests++;
    if (done_cnt - d0 !== 64) begin
      fails++;
      $display("FAIL random_frames: got %0d expected 64", done_cnt - d0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [4:0] obs, ev;
    int         d0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_byte  = 8'h3C;
    @(negedge clk);
    tx_byte = 8'h11;
    @(negedge clk);
    tx_byte = 8'h22;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (13) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    obs = {tx, tx_ready, fifo_empty, is_transmitting, tx_done};
    tests++;
    if (obs !== 5'b11100) begin
      fails++;
      $display("FAIL midframe_async: got %b expected %b", obs, 5'b11100);
    end
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    tx_valid = 1'b1;
    tx_byte  = 8'h81;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (FRAME + 5) begin
      @(negedge clk);
      obs = {tx, tx_ready, fifo_empty, is_transmitting, tx_done};
      ev  = model_exp();
      tests++;
      if (obs !== ev) begin
        fails++;
        $display("FAIL midframe_recover: got %b expected %b at %0t", obs, ev, $time);
      end
    end
    tests++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL midframe_done_count: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_push_on_pop();
    logic [4:0] obs, ev;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_byte  = 8'hA5;
    @(negedge clk);
    tx_byte = 8'h5A;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (39) @(negedge clk);
    tx_valid = 1'b1;
    tx_byte  = 8'hC3;
    @(negedge clk);
    tx_valid = 1'b0;
    tests++;
    if ({fifo_empty, tx_ready, is_transmitting} !== 3'b011) begin
      fails++;
      $display("FAIL pushpop_count: got %b expected 011", {fifo_empty, tx_ready, is_transmitting});
    end
    repeat (39) @(negedge clk);
    tests++;
    if (fifo_empty !== 1'b0) begin
      fails++;
      $display("FAIL pushpop_held: fifo_empty got %b expected 0", fifo_empty);
    end
    @(negedge clk);
    tests++;
    if (fifo_empty !== 1'b1) begin
      fails++;
      $display("FAIL pushpop_popped: fifo_empty got %b expected 1", fifo_empty);
    end
    repeat (FRAME + 5) begin
      @(negedge clk);
      obs = {tx, tx_ready, fifo_empty, is_transmitting, tx_done};
      ev  = model_exp();
      tests++;
      if (obs !== ev) begin
        fails++;
        $display("FAIL pushpop_line: got %b expected %b at %0t", obs, ev, $time);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_push_on_pop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
